// File: rtl/control_pkg.sv
// Shared types and encodings for the multi-cycle RV32I control unit.
// Holds the FSM state enum, the decoded opcodes, the internal ALU-op
// encoding, the alucontrol encoding, the datapath mux select encodings,
// and a helper that picks the immediate format from the opcode.
package control_pkg;

    typedef enum logic [3:0] {
        StFetch,
        StDecode,
        StMemAdr,
        StMemRd,
        StMemWb,
        StMemWr,
        StExecR,
        StExecI,
        StAluWb,
        StBeq,
        StJal,
        StHalt
    } state_t;

    localparam logic [6:0] OpLoad  = 7'b0000011;
    localparam logic [6:0] OpStore = 7'b0100011;
    localparam logic [6:0] OpRtype = 7'b0110011;
    localparam logic [6:0] OpItype = 7'b0010011;
    localparam logic [6:0] OpBeq   = 7'b1100011;
    localparam logic [6:0] OpJal   = 7'b1101111;

    typedef enum logic [1:0] {
        AluOpAdd   = 2'b00,
        AluOpSub   = 2'b01,
        AluOpFunct = 2'b10
    } aluop_t;

    localparam logic [2:0] AluAdd = 3'b000;
    localparam logic [2:0] AluSub = 3'b001;
    localparam logic [2:0] AluAnd = 3'b010;
    localparam logic [2:0] AluOr  = 3'b011;
    localparam logic [2:0] AluSlt = 3'b101;

    localparam logic [1:0] SrcAPc    = 2'b00;
    localparam logic [1:0] SrcAOldPc = 2'b01;
    localparam logic [1:0] SrcARs1   = 2'b10;

    localparam logic [1:0] SrcBRs2  = 2'b00;
    localparam logic [1:0] SrcBImm  = 2'b01;
    localparam logic [1:0] SrcBFour = 2'b10;

    localparam logic [1:0] ResAluOut    = 2'b00;
    localparam logic [1:0] ResMemData   = 2'b01;
    localparam logic [1:0] ResAluResult = 2'b10;

    localparam logic [1:0] ImmI = 2'b00;
    localparam logic [1:0] ImmS = 2'b01;
    localparam logic [1:0] ImmB = 2'b10;
    localparam logic [1:0] ImmJ = 2'b11;

    // Immediate format depends only on the opcode, so it is valid in every state.
    function automatic logic [1:0] imm_sel(input logic [6:0] op);
        unique case (op)
            OpStore: imm_sel = ImmS;
            OpBeq:   imm_sel = ImmB;
            OpJal:   imm_sel = ImmJ;
            default: imm_sel = ImmI;
        endcase
    endfunction

endpackage

// File: rtl/multicycle_control_if.sv
// Control/datapath bundle for the multi-cycle core.
// slave  : the control unit (takes instruction fields and status, drives selects/strobes).
// master : the datapath side (drives instruction fields and status, takes selects/strobes).
interface multicycle_control_if;
    logic [6:0] op;
    logic [2:0] funct3;
    logic       funct7b5;
    logic       zero;
    logic       mem_ready;
    logic [1:0] immsrc;
    logic [1:0] alusrca;
    logic [1:0] alusrcb;
    logic [2:0] alucontrol;
    logic [1:0] resultsrc;
    logic       adrsrc;
    logic       irwrite;
    logic       pcwrite;
    logic       regwrite;
    logic       memwrite;
    logic       illegal;

    modport slave (
        input  op, funct3, funct7b5, zero, mem_ready,
        output immsrc, alusrca, alusrcb, alucontrol, resultsrc, adrsrc,
               irwrite, pcwrite, regwrite, memwrite, illegal
    );

    modport master (
        output op, funct3, funct7b5, zero, mem_ready,
        input  immsrc, alusrca, alusrcb, alucontrol, resultsrc, adrsrc,
               irwrite, pcwrite, regwrite, memwrite, illegal
    );
endinterface

// File: rtl/alu_decoder.sv
// Combinational ALU decoder.
// aluop_i      : internal ALU op (add / sub / decode from funct3)
// funct3_i     : instr[14:12]
// op5_i        : instr[5], separates R-type from I-type
// funct7b5_i   : instr[30]
// alucontrol_o : ALU function select
module alu_decoder
    import control_pkg::*;
(
    input  aluop_t     aluop_i,
    input  logic [2:0] funct3_i,
    input  logic       op5_i,
    input  logic       funct7b5_i,
    output logic [2:0] alucontrol_o
);

    always_comb begin
        alucontrol_o = AluAdd;
        unique case (aluop_i)
            AluOpSub: alucontrol_o = AluSub;
            AluOpFunct: begin
                unique case (funct3_i)
                    // addi has no funct7 field, so only R-type may select sub.
                    3'b000:  alucontrol_o = (op5_i & funct7b5_i) ? AluSub : AluAdd;
                    3'b010:  alucontrol_o = AluSlt;
                    3'b110:  alucontrol_o = AluOr;
                    3'b111:  alucontrol_o = AluAnd;
                    default: alucontrol_o = AluAdd;
                endcase
            end
            default: alucontrol_o = AluAdd;
        endcase
    end

endmodule

// File: rtl/multicycle_control.sv
// Sequencing FSM for the multi-cycle RV32I core (lw, sw, R-ALU, I-ALU, beq, jal).
// clk, rst : clock, synchronous active-high reset
// bus_io   : slave side of multicycle_control_if; instruction fields, zero and
//            mem_ready in; mux selects, alucontrol, immsrc, write strobes and
//            illegal out.
// STRICT_DECODE : 1 = unknown opcode halts (sticky), 0 = unknown opcode is skipped.
module multicycle_control
    import control_pkg::*;
#(
    parameter bit STRICT_DECODE = 1'b1
) (
    input logic                  clk,
    input logic                  rst,
    multicycle_control_if.slave  bus_io
);

    state_t state_q, state_d;
    aluop_t aluop;
    logic   pcupdate, branch;
    logic   irwrite, regwrite, memwrite, illegal;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StFetch;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StFetch:  if (bus_io.mem_ready) state_d = StDecode;
            StDecode: begin
                unique case (bus_io.op)
                    OpLoad, OpStore: state_d = StMemAdr;
                    OpRtype:         state_d = StExecR;
                    OpItype:         state_d = StExecI;
                    OpBeq:           state_d = StBeq;
                    OpJal:           state_d = StJal;
                    default:         state_d = STRICT_DECODE ? StHalt : StFetch;
                endcase
            end
            StMemAdr: state_d = bus_io.op[5] ? StMemWr : StMemRd;
            StMemRd:  if (bus_io.mem_ready) state_d = StMemWb;
            StMemWb:  state_d = StFetch;
            StMemWr:  if (bus_io.mem_ready) state_d = StFetch;
            StExecR:  state_d = StAluWb;
            StExecI:  state_d = StAluWb;
            StAluWb:  state_d = StFetch;
            StBeq:    state_d = StFetch;
            StJal:    state_d = StAluWb;
            StHalt:   state_d = StHalt;
            default:  state_d = StFetch;
        endcase
    end

    always_comb begin
        bus_io.alusrca   = SrcAPc;
        bus_io.alusrcb   = SrcBRs2;
        bus_io.resultsrc = ResAluOut;
        bus_io.adrsrc    = 1'b0;
        aluop            = AluOpAdd;
        irwrite          = 1'b0;
        pcupdate         = 1'b0;
        branch           = 1'b0;
        regwrite         = 1'b0;
        memwrite         = 1'b0;
        illegal          = 1'b0;
        unique case (state_q)
            StFetch: begin
                bus_io.alusrcb   = SrcBFour;
                bus_io.resultsrc = ResAluResult;
                irwrite          = bus_io.mem_ready;
                pcupdate         = bus_io.mem_ready;
            end
            StDecode: begin
                // Precompute the branch/jump target into ALUOut.
                bus_io.alusrca = SrcAOldPc;
                bus_io.alusrcb = SrcBImm;
            end
            StMemAdr: begin
                bus_io.alusrca = SrcARs1;
                bus_io.alusrcb = SrcBImm;
            end
            StMemRd:  bus_io.adrsrc = 1'b1;
            StMemWb: begin
                bus_io.resultsrc = ResMemData;
                regwrite         = 1'b1;
            end
            StMemWr: begin
                bus_io.adrsrc = 1'b1;
                memwrite      = 1'b1;
            end
            StExecR: begin
                bus_io.alusrca = SrcARs1;
                aluop          = AluOpFunct;
            end
            StExecI: begin
                bus_io.alusrca = SrcARs1;
                bus_io.alusrcb = SrcBImm;
                aluop          = AluOpFunct;
            end
            StAluWb:  regwrite = 1'b1;
            StBeq: begin
                bus_io.alusrca = SrcARs1;
                aluop          = AluOpSub;
                branch         = 1'b1;
            end
            StJal: begin
                // ALU computes oldPC+4 for rd while the PC takes the target in ALUOut.
                bus_io.alusrca = SrcAOldPc;
                bus_io.alusrcb = SrcBFour;
                pcupdate       = 1'b1;
            end
            StHalt:   illegal = 1'b1;
            default: ;
        endcase
    end

    // Reset masks every strobe in the same cycle so an abandoned instruction writes nothing.
    assign bus_io.irwrite  = irwrite & ~rst;
    assign bus_io.pcwrite  = (pcupdate | (branch & bus_io.zero)) & ~rst;
    assign bus_io.regwrite = regwrite & ~rst;
    assign bus_io.memwrite = memwrite & ~rst;
    assign bus_io.illegal  = illegal & ~rst;
    assign bus_io.immsrc   = imm_sel(bus_io.op);

    alu_decoder u_alu_decoder (
        .aluop_i      (aluop),
        .funct3_i     (bus_io.funct3),
        .op5_i        (bus_io.op[5]),
        .funct7b5_i   (bus_io.funct7b5),
        .alucontrol_o (bus_io.alucontrol)
    );

endmodule

// File: tb/tb_multicycle_control.sv
// Directed bench for multicycle_control: one strict and one lax instance share
// stimulus; each cycle the packed output vector is compared to a hand-built value.
module tb_multicycle_control;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    multicycle_control_if bus_s ();
    multicycle_control_if bus_l ();

    multicycle_control #(.STRICT_DECODE(1'b1)) u_dut (
        .clk    (clk),
        .rst    (rst),
        .bus_io (bus_s)
    );

    multicycle_control #(.STRICT_DECODE(1'b0)) u_lax (
        .clk    (clk),
        .rst    (rst),
        .bus_io (bus_l)
    );

    // {immsrc, alusrca, alusrcb, alucontrol, resultsrc, adrsrc, ir, pc, rw, mw, illegal}
    logic [16:0] obs_s, obs_l;
    assign obs_s = {bus_s.immsrc, bus_s.alusrca, bus_s.alusrcb, bus_s.alucontrol,
                    bus_s.resultsrc, bus_s.adrsrc, bus_s.irwrite, bus_s.pcwrite,
                    bus_s.regwrite, bus_s.memwrite, bus_s.illegal};
    assign obs_l = {bus_l.immsrc, bus_l.alusrca, bus_l.alusrcb, bus_l.alucontrol,
                    bus_l.resultsrc, bus_l.adrsrc, bus_l.irwrite, bus_l.pcwrite,
                    bus_l.regwrite, bus_l.memwrite, bus_l.illegal};

    int total = 0;
    int bad   = 0;

    function automatic logic [16:0] ev(input int imm, input int a, input int b, input int alu,
                                       input int res, input int adr, input int ir, input int pc,
                                       input int rw, input int mw, input int ill);
        ev = {imm[1:0], a[1:0], b[1:0], alu[2:0], res[1:0], adr[0], ir[0], pc[0], rw[0],
              mw[0], ill[0]};
    endfunction

    task automatic check_eq(input string tag, input logic [16:0] obs, input logic [16:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %b want %b", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic [6:0] op, input logic [2:0] f3, input logic f7,
                         input logic z, input logic rdy);
        bus_s.op = op; bus_s.funct3 = f3; bus_s.funct7b5 = f7;
        bus_s.zero = z; bus_s.mem_ready = rdy;
        bus_l.op = op; bus_l.funct3 = f3; bus_l.funct7b5 = f7;
        bus_l.zero = z; bus_l.mem_ready = rdy;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Apply inputs for the current state, check the strict instance, advance one cycle.
    task automatic run(input string tag, input logic [6:0] op, input logic [2:0] f3,
                       input logic f7, input logic z, input logic rdy, input logic [16:0] exp);
        drive(op, f3, f7, z, rdy);
        #1;
        check_eq(tag, obs_s, exp);
        step();
    endtask

    localparam logic [6:0] LW  = 7'b0000011;
    localparam logic [6:0] SW  = 7'b0100011;
    localparam logic [6:0] RT  = 7'b0110011;
    localparam logic [6:0] IT  = 7'b0010011;
    localparam logic [6:0] BEQ = 7'b1100011;
    localparam logic [6:0] JAL = 7'b1101111;
    localparam logic [6:0] UNK = 7'b0000000;

    initial begin
        rst = 1'b1;
        drive(LW, 3'b010, 1'b0, 1'b0, 1'b1);
        step();
        step();
        #1;
        check_eq("rst_fetch_masked", obs_s, ev(0, 0, 2, 0, 2, 0, 0, 0, 0, 0, 0));
        rst = 1'b0;

        // lw with one stall in FETCH and one in MEMRD
        run("lw_fetch_stall", LW, 3'b010, 0, 0, 0, ev(0, 0, 2, 0, 2, 0, 0, 0, 0, 0, 0));
        run("lw_fetch",       LW, 3'b010, 0, 0, 1, ev(0, 0, 2, 0, 2, 0, 1, 1, 0, 0, 0));
        run("lw_decode",      LW, 3'b010, 0, 0, 0, ev(0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0));
        run("lw_memadr",      LW, 3'b010, 0, 0, 0, ev(0, 2, 1, 0, 0, 0, 0, 0, 0, 0, 0));
        run("lw_memrd_stall", LW, 3'b010, 0, 0, 0, ev(0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0));
        run("lw_memrd",       LW, 3'b010, 0, 0, 1, ev(0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0));
        run("lw_memwb",       LW, 3'b010, 0, 0, 1, ev(0, 0, 0, 0, 1, 0, 0, 0, 1, 0, 0));

        // sw, three wait cycles in MEMWR
        run("sw_fetch",  SW, 3'b010, 0, 0, 1, ev(1, 0, 2, 0, 2, 0, 1, 1, 0, 0, 0));
        run("sw_decode", SW, 3'b010, 0, 0, 1, ev(1, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0));
        run("sw_memadr", SW, 3'b010, 0, 0, 1, ev(1, 2, 1, 0, 0, 0, 0, 0, 0, 0, 0));
        for (int i = 0; i < 3; i++)
            run("sw_memwr_wait", SW, 3'b010, 0, 0, 0, ev(1, 0, 0, 0, 0, 1, 0, 0, 0, 1, 0));
        run("sw_memwr_done", SW, 3'b010, 0, 0, 1, ev(1, 0, 0, 0, 0, 1, 0, 0, 0, 1, 0));

        // beq taken then not taken
        run("beq1_fetch",  BEQ, 3'b000, 0, 1, 1, ev(2, 0, 2, 0, 2, 0, 1, 1, 0, 0, 0));
        run("beq1_decode", BEQ, 3'b000, 0, 1, 1, ev(2, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0));
        run("beq1_taken",  BEQ, 3'b000, 0, 1, 1, ev(2, 2, 0, 1, 0, 0, 0, 1, 0, 0, 0));
        run("beq0_fetch",  BEQ, 3'b000, 0, 0, 1, ev(2, 0, 2, 0, 2, 0, 1, 1, 0, 0, 0));
        run("beq0_decode", BEQ, 3'b000, 0, 0, 1, ev(2, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0));
        run("beq0_nottkn", BEQ, 3'b000, 0, 0, 1, ev(2, 2, 0, 1, 0, 0, 0, 0, 0, 0, 0));

        // R-type sub
        run("rsub_fetch",  RT, 3'b000, 1, 0, 1, ev(0, 0, 2, 0, 2, 0, 1, 1, 0, 0, 0));
        run("rsub_decode", RT, 3'b000, 1, 0, 1, ev(0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0));
        run("rsub_exec",   RT, 3'b000, 1, 0, 1, ev(0, 2, 0, 1, 0, 0, 0, 0, 0, 0, 0));
        run("rsub_aluwb",  RT, 3'b000, 1, 0, 1, ev(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0));

        // addi with funct7b5 set must still add
        run("addi_fetch",  IT, 3'b000, 1, 0, 1, ev(0, 0, 2, 0, 2, 0, 1, 1, 0, 0, 0));
        run("addi_decode", IT, 3'b000, 1, 0, 1, ev(0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0));
        run("addi_exec",   IT, 3'b000, 1, 0, 1, ev(0, 2, 1, 0, 0, 0, 0, 0, 0, 0, 0));
        run("addi_aluwb",  IT, 3'b000, 1, 0, 1, ev(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0));

        // R-type or
        run("ror_fetch",  RT, 3'b110, 0, 0, 1, ev(0, 0, 2, 0, 2, 0, 1, 1, 0, 0, 0));
        run("ror_decode", RT, 3'b110, 0, 0, 1, ev(0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0));
        run("ror_exec",   RT, 3'b110, 0, 0, 1, ev(0, 2, 0, 3, 0, 0, 0, 0, 0, 0, 0));
        run("ror_aluwb",  RT, 3'b110, 0, 0, 1, ev(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0));

        // jal
        run("jal_fetch",  JAL, 3'b000, 0, 0, 1, ev(3, 0, 2, 0, 2, 0, 1, 1, 0, 0, 0));
        run("jal_decode", JAL, 3'b000, 0, 0, 1, ev(3, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0));
        run("jal_jal",    JAL, 3'b000, 0, 0, 1, ev(3, 1, 2, 0, 0, 0, 0, 1, 0, 0, 0));
        run("jal_aluwb",  JAL, 3'b000, 0, 0, 1, ev(3, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0));

        // unknown opcode: strict halts, lax returns to FETCH
        run("unk_fetch",  UNK, 3'b000, 0, 0, 1, ev(0, 0, 2, 0, 2, 0, 1, 1, 0, 0, 0));
        run("unk_decode", UNK, 3'b000, 0, 0, 1, ev(0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0));
        drive(UNK, 3'b000, 1'b0, 1'b1, 1'b1);
        #1;
        check_eq("halt_strict", obs_s, ev(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1));
        check_eq("lax_refetch", obs_l, ev(0, 0, 2, 0, 2, 0, 1, 1, 0, 0, 0));
        step();
        run("halt_sticky", BEQ, 3'b000, 0, 1, 1, ev(2, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1));
        rst = 1'b1;
        run("halt_rst_cyc", UNK, 3'b000, 0, 0, 1, ev(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        run("rst_exit",     UNK, 3'b000, 0, 0, 1, ev(0, 0, 2, 0, 2, 0, 0, 0, 0, 0, 0));
        rst = 1'b0;

        // reset in MEMWR: memwrite masked, next state FETCH
        run("sw2_fetch",  SW, 3'b010, 0, 0, 1, ev(1, 0, 2, 0, 2, 0, 1, 1, 0, 0, 0));
        run("sw2_decode", SW, 3'b010, 0, 0, 1, ev(1, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0));
        run("sw2_memadr", SW, 3'b010, 0, 0, 1, ev(1, 2, 1, 0, 0, 0, 0, 0, 0, 0, 0));
        rst = 1'b1;
        run("sw2_rst_memwr", SW, 3'b010, 0, 0, 0, ev(1, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0));
        rst = 1'b0;
        run("sw2_after_rst", SW, 3'b010, 0, 0, 0, ev(1, 0, 2, 0, 2, 0, 0, 0, 0, 0, 0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
